adc_spi_conv: RTL and testbench

- SPI master for the 8-channel 12-bit slide-pot ADC.
- On a strt_cnv request it runs two back-to-back 16-bit SPI frames:
  - frame 1 sends the channel select;
  - frame 2 reads the conversion result.
- It then returns the 12-bit result with a one-cycle completion strobe.
- It sits directly upstream of the pot round-robin sequencer, which drives chnnl/strt_cnv and consumes res/cnv_cmplt.

---
 rtl/adc_spi_conv_pkg.sv | 11 +
 rtl/adc_spi_conv_spi_frame16.sv | 63 ++++++
 rtl/adc_spi_conv.sv | 73 +++++++
 tb/tb_adc_spi_conv.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_conv_pkg.sv
// a2d_pkg: shared state type and constants for the slide-pot ADC SPI master
package a2d_pkg;
  typedef enum logic [2:0] {IDLE, FRM1, GAP, FRM2, DONE} conv_state_t;
  localparam logic [2:0] CH_B1  = 3'd0;
  localparam logic [2:0] CH_LP  = 3'd1;
  localparam logic [2:0] CH_B3  = 3'd2;
  localparam logic [2:0] CH_HP  = 3'd3;
  localparam logic [2:0] CH_B2  = 3'd4;
  localparam logic [2:0] CH_VOL = 3'd7;
  localparam int FRAME_BITS = 16;
endpackage

// File: rtl/adc_spi_conv_spi_frame16.sv
// spi_frame16: one 16-bit SPI frame, SCLK idles high, MOSI changes on fall, MISO sampled on rise
module spi_frame16 import a2d_pkg::*; #(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt,
  input  logic [15:0] tx_data,
  input  logic        MISO,
  output logic        done,
  output logic [15:0] rx_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);
  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] PRE = CW'(SCLK_DIV * 3 / 4 - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(SCLK_DIV / 2 - 1);
  logic [CW-1:0] cnt, cnt_nxt;
  logic [4:0] bit_cnt;
  logic [15:0] tx_shift, rx_shift;
  logic first, wrap, rise;
  assign cnt_nxt = cnt + 1'b1;
  assign wrap = !SS_n && cnt == '1;
  assign rise = !SS_n && cnt == HALF_M1;
  assign done = wrap && bit_cnt == 5'(FRAME_BITS);
  assign MOSI = tx_shift[15];
  assign rx_data = rx_shift;
  // frame engine: divider, bit counter and both shift registers; the 17th wrap ends the frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      bit_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      first <= 1'b0;
      SS_n <= 1'b1;
      SCLK <= 1'b1;
    end else if (strt && SS_n) begin
      cnt <= PRE;
      bit_cnt <= '0;
      tx_shift <= tx_data;
      rx_shift <= '0;
      first <= 1'b1;
      SS_n <= 1'b0;
      SCLK <= PRE[CW-1];
    end else if (done) begin
      cnt <= '0;
      bit_cnt <= '0;
      tx_shift <= '0;
      SS_n <= 1'b1;
      SCLK <= 1'b1;
    end else if (!SS_n) begin
      cnt <= cnt_nxt;
      SCLK <= cnt_nxt[CW-1];
      first <= first && !wrap;
      if (wrap && !first) tx_shift <= {tx_shift[14:0], 1'b0};
      if (rise) begin
        rx_shift <= {rx_shift[14:0], MISO};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
endmodule

// File: rtl/adc_spi_conv.sv
// adc_spi_conv: channel-select frame, SS_n gap, result frame, then a one-cycle completion strobe
module adc_spi_conv import a2d_pkg::*; #(
  parameter int SCLK_DIV = 32,
  parameter int GAP_CLKS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  input  logic        MISO,
  output logic        cnv_cmplt,
  output logic [11:0] res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI
);
  localparam int GW = $clog2(GAP_CLKS + 1);
  conv_state_t state;
  logic [2:0] chnl_q;
  logic [GW-1:0] gap_cnt;
  logic f_strt, f_done;
  logic [15:0] f_tx, rx_data;
  assign f_tx = (state == FRM1) ? {2'b00, chnl_q, 11'h000} : 16'h0000;
  spi_frame16 #(.SCLK_DIV(SCLK_DIV)) u_frm (
    .clk,
    .rst_n,
    .strt(f_strt),
    .tx_data(f_tx),
    .MISO,
    .done(f_done),
    .rx_data,
    .SS_n,
    .SCLK,
    .MOSI
  );
  // outer sequencer: the frame start fires one cycle early so SS_n stays high exactly GAP_CLKS cycles
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      chnl_q <= '0;
      gap_cnt <= '0;
      f_strt <= 1'b0;
      cnv_cmplt <= 1'b0;
      res <= '0;
    end else begin
      f_strt <= 1'b0;
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: if (strt_cnv) begin
          chnl_q <= chnnl;
          f_strt <= 1'b1;
          state <= FRM1;
        end
        FRM1: if (f_done) begin
          gap_cnt <= '0;
          state <= GAP;
        end
        GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (gap_cnt == GW'(GAP_CLKS - 2)) begin
            f_strt <= 1'b1;
            state <= FRM2;
          end
        end
        FRM2: if (f_done) begin
          res <= rx_data[11:0];
          cnv_cmplt <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_adc_spi_conv.sv
// tb_adc_spi_conv: randomized scenarios against an ADC slave model and spec-level expectations
module tb_adc_spi_conv;
  logic clk = 1'b0, rst_n = 1'b0, strt_cnv = 1'b0, MISO = 1'b0;
  logic [2:0] chnnl = 3'd0;
  logic cnv_cmplt, SS_n, SCLK, MOSI;
  logic [11:0] res;
  int n_chk = 0, n_fail = 0;
  int fcnt = 0, bit_i = 0;
  int rises [2] = '{0, 0};
  logic [15:0] mosi_w [2];
  logic [15:0] cur = 16'h0, slv_res = 16'h0;

  always #5 clk = ~clk;

  adc_spi_conv dut (
    .clk(clk), .rst_n(rst_n), .strt_cnv(strt_cnv), .chnnl(chnnl), .MISO(MISO),
    .cnv_cmplt(cnv_cmplt), .res(res), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI)
  );

  // ADC slave: frame 1 answers junk, frame 2 answers slv_res, MSB first, next bit after each rise
  always @(negedge SS_n) begin
    fcnt++;
    cur = (fcnt == 2) ? slv_res : 16'($urandom);
    bit_i = 15;
    if (fcnt >= 1 && fcnt <= 2) begin
      rises[fcnt-1] = 0;
      mosi_w[fcnt-1] = 16'h0;
    end
    MISO = cur[15];
  end

  // capture MOSI and count SCLK rises per frame
  always @(posedge SCLK) if (!SS_n && fcnt >= 1 && fcnt <= 2) begin
    rises[fcnt-1]++;
    mosi_w[fcnt-1] = {mosi_w[fcnt-1][14:0], MOSI};
    bit_i--;
    MISO = (bit_i >= 0) ? cur[bit_i] : 1'b0;
  end

  task automatic run_conv(input logic [2:0] ch, input logic [15:0] w, input int busy_at,
                          input logic [2:0] busy_ch, output int lat, output int gap,
                          output bit moved, output bit viol);
    logic [11:0] r0;
    @(negedge clk);
    r0 = res;
    slv_res = w;
    fcnt = 0;
    chnnl = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    chnnl = 3'($urandom);
    lat = 0;
    gap = 0;
    moved = 1'b0;
    viol = 1'b0;
    while (lat < 2000) begin
      @(negedge clk);
      lat++;
      strt_cnv = (lat == busy_at);
      if (lat == busy_at) chnnl = busy_ch;
      if (fcnt == 1 && SS_n) gap++;
      if (SS_n && !SCLK) viol = 1'b1;
      if (cnv_cmplt) break;
      if (res !== r0) moved = 1'b1;
    end
    strt_cnv = 1'b0;
  endtask

  task automatic test_reset();
    bit moved = 1'b0;
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      strt_cnv = ~strt_cnv;
      chnnl = 3'($urandom);
    end
    @(negedge clk);
    n_chk++;
    if ({SS_n, SCLK, MOSI, cnv_cmplt, res} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_hold: got ss=%b sclk=%b mosi=%b cmplt=%b res=%h expected 1 1 0 0 000", SS_n, SCLK, MOSI, cnv_cmplt, res);
    end
    strt_cnv = 1'b0;
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if ({SS_n, SCLK, MOSI, cnv_cmplt, res} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'h000}) moved = 1'b1;
    end
    n_chk++;
    if (moved !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: outputs moved=%b expected 0", moved);
    end
  endtask

  task automatic test_basic();
    int lat, gap;
    bit moved, viol;
    run_conv(3'd5, 16'h0ABC, 0, 3'd0, lat, gap, moved, viol);
    n_chk++;
    if (mosi_w[0] !== 16'(3'd5) << 11) begin n_fail++; $display("FAIL basic_cmd: got %h expected %h", mosi_w[0], 16'(3'd5) << 11); end
    n_chk++;
    if (rises[0] != 16 || rises[1] != 16) begin n_fail++; $display("FAIL basic_rises: got %0d/%0d expected 16/16", rises[0], rises[1]); end
    n_chk++;
    if (gap != 32) begin n_fail++; $display("FAIL basic_gap: got %0d expected 32", gap); end
    n_chk++;
    if (res !== 12'hABC) begin n_fail++; $display("FAIL basic_res: got %h expected abc", res); end
    n_chk++;
    if (lat < 1070 || lat > 1080) begin n_fail++; $display("FAIL basic_latency: got %0d expected 1070..1080", lat); end
    n_chk++;
    if (viol !== 1'b0) begin n_fail++; $display("FAIL basic_sclk_idle: SCLK low with SS_n high"); end
    @(negedge clk);
    n_chk++;
    if (cnv_cmplt !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: cmplt=%b expected 0", cnv_cmplt); end
  endtask

  task automatic test_mask();
    int lat, gap;
    bit moved, viol;
    logic [2:0] ch = 3'($urandom);
    run_conv(ch, 16'hF123, 0, 3'd0, lat, gap, moved, viol);
    n_chk++;
    if (moved !== 1'b0) begin n_fail++; $display("FAIL mask_res_held: res changed before completion"); end
    n_chk++;
    if (res !== 12'h123) begin n_fail++; $display("FAIL mask_res: got %h expected 123", res); end
    n_chk++;
    if (mosi_w[0] !== 16'(ch) << 11) begin n_fail++; $display("FAIL mask_cmd: got %h expected %h", mosi_w[0], 16'(ch) << 11); end
  endtask

  task automatic test_busy();
    int lat, gap, extra = 0;
    bit moved, viol;
    logic [15:0] w = 16'($urandom);
    run_conv(3'd1, w, 100, 3'd7, lat, gap, moved, viol);
    n_chk++;
    if (mosi_w[0] !== 16'h0800) begin n_fail++; $display("FAIL busy_cmd: got %h expected 0800", mosi_w[0]); end
    n_chk++;
    if (res !== w[11:0]) begin n_fail++; $display("FAIL busy_res: got %h expected %h", res, w[11:0]); end
    n_chk++;
    if (lat < 1070 || lat > 1080) begin n_fail++; $display("FAIL busy_latency: got %0d expected 1070..1080", lat); end
    repeat (1200) begin
      @(negedge clk);
      if (cnv_cmplt) extra++;
    end
    n_chk++;
    if (extra != 0 || fcnt != 2) begin n_fail++; $display("FAIL busy_no_requeue: extra pulses %0d frames %0d expected 0 and 2", extra, fcnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      int lat, gap;
      bit moved, viol;
      logic [2:0] ch = 3'($urandom);
      logic [15:0] w = 16'($urandom);
      run_conv(ch, w, 0, 3'd0, lat, gap, moved, viol);
      n_chk++;
      if (res !== w[11:0] || mosi_w[0] !== 16'(ch) << 11 || gap != 32 || viol) begin
        n_fail++;
        $display("FAIL random_%0d: res %h cmd %h gap %0d viol %b expected %h %h 32 0", i, res, mosi_w[0], gap, viol, w[11:0], 16'(ch) << 11);
      end
    end
  endtask

  task automatic test_reset_mid();
    int k = 0, lat, gap;
    bit moved, viol, bad = 1'b0;
    logic [15:0] w = 16'($urandom);
    @(negedge clk);
    fcnt = 0;
    slv_res = 16'($urandom);
    chnnl = 3'd3;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
    while (!(fcnt == 2 && rises[1] == 8) && k < 3000) begin @(negedge clk); k++; end
    while (SCLK && k < 3000) begin @(negedge clk); k++; end
    n_chk++;
    if (k >= 3000) begin n_fail++; $display("FAIL reset_mid_reach: timeout waiting for bit 8 of frame 2"); end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if ({SS_n, SCLK, MOSI, cnv_cmplt, res} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'h000}) begin
      n_fail++;
      $display("FAIL reset_mid_async: got ss=%b sclk=%b mosi=%b cmplt=%b res=%h expected 1 1 0 0 000", SS_n, SCLK, MOSI, cnv_cmplt, res);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (1200) begin
      @(negedge clk);
      if (cnv_cmplt || !SS_n || res !== 12'h000) bad = 1'b1;
    end
    n_chk++;
    if (bad !== 1'b0) begin n_fail++; $display("FAIL reset_mid_quiet: activity after abort=%b expected 0", bad); end
    run_conv(3'd2, w, 0, 3'd0, lat, gap, moved, viol);
    n_chk++;
    if (res !== w[11:0] || lat < 1070 || lat > 1080) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: res %h lat %0d expected %h 1070..1080", res, lat, w[11:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] chans [6] = '{3'd1, 3'd0, 3'd4, 3'd2, 3'd3, 3'd7};
    foreach (chans[i]) begin
      int lat, gap;
      bit moved, viol;
      logic [15:0] w = {4'($urandom), 12'h100 + 12'(chans[i])};
      run_conv(chans[i], w, 0, 3'd0, lat, gap, moved, viol);
      n_chk++;
      if (res !== 12'h100 + 12'(chans[i])) begin n_fail++; $display("FAIL b2b_res_%0d: got %h expected %h", i, res, 12'h100 + 12'(chans[i])); end
      n_chk++;
      if (lat < 1070 || lat > 1080) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d expected 1070..1080", i, lat); end
      n_chk++;
      if (mosi_w[0] !== 16'(chans[i]) << 11) begin n_fail++; $display("FAIL b2b_cmd_%0d: got %h expected %h", i, mosi_w[0], 16'(chans[i]) << 11); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_busy();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
